// File: rtl/gsim_mem_responder.sv
// GSIM matrix read-port responder: queues solver row requests, issues them to a
// single-port SRAM and returns rows in order. Optional GSIM_RRDY_THROTTLE_EN masks rrdy with an LFSR.
module gsim_mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 256,
  parameter int SRAM_LAT  = 1,
  parameter int REQ_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_mem_rreq,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              o_mem_rrdy,
  output logic [DATA_W-1:0] o_mem_dout,
  output logic              o_mem_dout_vld,
  input  logic              i_sram_busy,
  output logic              o_sram_cen,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [DATA_W-1:0] i_sram_q
);

  localparam int PTR_W = $clog2(REQ_DEPTH);

  logic [ADDR_W-1:0]   fifo [REQ_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                full, empty, push, pop, rrdy_raw;
  logic [SRAM_LAT-1:0] vld_pipe;
  logic                tail;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_vld_q;

  assign full     = (count == (PTR_W+1)'(REQ_DEPTH));
  assign empty    = (count == '0);
  // full/empty come from the count register only; no path from i_mem_rreq to rrdy
  assign rrdy_raw = i_en & ~full & ~i_reset;

`ifdef GSIM_RRDY_THROTTLE_EN
  logic [7:0] lfsr;

  always_ff @(posedge i_clk) begin
    if (i_reset)   lfsr <= 8'hA5;
    else if (i_en) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign o_mem_rrdy = rrdy_raw & ~lfsr[0];
`else
  assign o_mem_rrdy = rrdy_raw;
`endif

  assign push        = i_mem_rreq & o_mem_rrdy;
  assign o_sram_cen  = i_en & ~empty & ~i_sram_busy;
  assign pop         = o_sram_cen;
  assign o_sram_addr = o_sram_cen ? fifo[rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (push) fifo[wr_ptr] <= i_mem_addr;
  end

  // Disabling the block flushes the queue every cycle
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign tail = vld_pipe[SRAM_LAT-1];

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      vld_pipe   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      vld_pipe   <= (vld_pipe << 1) | SRAM_LAT'(o_sram_cen);
      dout_vld_q <= tail;
      dout_q     <= tail ? i_sram_q : '0;
    end
  end

  // A row registered just before i_en drops is discarded like any in-flight read
  assign o_mem_dout_vld = dout_vld_q & i_en;
  assign o_mem_dout     = o_mem_dout_vld ? dout_q : '0;

endmodule

// File: doc/gsim_mem_responder.md
# gsim_mem_responder

Synthesizable memory-side responder for the GSIM matrix read port. Accepts `rreq`/`addr` read requests from the solver, queues them, issues them to a synchronous single-port 256-bit matrix SRAM, and returns each row in request order on `dout`/`dout_vld`. It replaces the behavioural matrix memory used in simulation and is the block the solver talks to in the full chip.

## Interface
- `ADDR_W`, 10, request/SRAM address width
- `DATA_W`, 256, row width
- `SRAM_LAT`, 1, SRAM read latency in cycles (legal 1..4)
- `REQ_DEPTH`, 4, request FIFO depth (power of two, ≥2)

Ports:
- `i_clk`  in  1  clock; all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_en`  in  1  service enable (tied to solver `module_en`)
- `i_mem_rreq`  in  1  read request from solver
- `i_mem_addr`  in  ADDR_W  request row address
- `o_mem_rrdy`  out  1  request can be accepted this cycle
- `o_mem_dout`  out  DATA_W  returned row; all zeros when `o_mem_dout_vld`=0
- `o_mem_dout_vld`  out  1  one-cycle strobe per returned row
- `i_sram_busy`  in  1  SRAM unavailable (refresh/test); no issue this cycle
- `o_sram_cen`  out  1  SRAM read enable, active-high
- `o_sram_addr`  out  ADDR_W  SRAM address
- `i_sram_q`  in  DATA_W  SRAM read data, valid `SRAM_LAT` cycles after the sampling edge

## Operation
- Accept: at an edge where `i_mem_rreq & o_mem_rrdy` is high, push `i_mem_addr` into the FIFO. A request seen while `o_mem_rrdy`=0 is ignored; the solver holds it.
- `o_mem_rrdy` = `i_en & !full`, driven from registers only. No push when full, even if a pop happens in the same cycle.
- Issue: `o_sram_cen` = `i_en & !empty & !i_sram_busy`; `o_sram_addr` = FIFO head, or 0 when `cen`=0. The FIFO pops at any edge where `cen`=1.
- Return tracking: a `SRAM_LAT`-deep valid shift register is loaded with `cen` at each edge. When its tail is set, `i_sram_q` is registered into `o_mem_dout` and `o_mem_dout_vld` goes high for one cycle. Otherwise `o_mem_dout` is 0.
- Ordering: strictly FIFO. There is no reordering, duplication or loss while `i_en`=1.
- Throughput: one request accepted and one row returned per cycle when `i_sram_busy`=0.
- `i_en` low: the FIFO is flushed at each edge. `rrdy`, `cen` and `dout_vld` are forced to 0. In-flight SRAM reads are discarded: their valid bits are cleared and the rows are not returned.
- Simultaneous push and pop with the FIFO not full: both occur and the count is unchanged.

## Timing
- Reset (`i_reset`=1 at an edge): FIFO empty, valid pipe cleared. `o_mem_rrdy`=0, `o_mem_dout_vld`=0, `o_mem_dout`=0, `o_sram_cen`=0, `o_sram_addr`=0.
- After reset deasserts with `i_en`=1, `o_mem_rrdy`=1 in the first cycle.
- Minimum latency: a request accepted at edge E0 drives `cen` in cycle E0→E1 and SRAM samples it at E1. `o_mem_dout_vld` is high in cycle E0+SRAM_LAT+1 → E0+SRAM_LAT+2.
  - Example: with `SRAM_LAT`=1, `vld` is high in the second cycle after acceptance.
- Each cycle of `i_sram_busy`=1 with a non-empty FIFO adds one cycle of latency to every queued request.
- Reset mid-operation overrides everything: all queued and in-flight requests are dropped and no `vld` follows.

## Configuration
- `GSIM_RRDY_THROTTLE_EN`
  - Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle while `i_en`=1. `o_mem_rrdy` is additionally masked to 0 whenever `lfsr[0]`=1. This stresses the solver's hold-request behaviour. Correctness and ordering are unchanged.
  - Undefined: no LFSR; `o_mem_rrdy` = `i_en & !full`.

## Test plan
- Single read, `SRAM_LAT`=1, SRAM[10'h005]=256'h…A5A5 -> `vld` high only in the second cycle after the accept edge, `dout`=256'h…A5A5; `dout`=0 in every other cycle.
- 16 back-to-back requests to addresses 0..15, `busy`=0 -> `rrdy` stays 1, 16 consecutive `vld` cycles carrying rows 0..15 in order.
- `i_sram_busy`=1 for 6 cycles with `rreq` held high -> 4 accepts then `rrdy`=0. After release, the FIFO drains in order and all 4 rows are returned with no duplicates.
- `i_en` dropped with 3 queued and 1 in flight -> next cycle `rrdy`=0 and `cen`=0, and no `vld` appears. After re-enable, a new request to 10'h3FF returns SRAM[10'h3FF] at minimum latency.
- `i_reset` pulsed mid-burst -> all outputs 0 after the reset edge; the first post-reset request is served normally.
- With `GSIM_RRDY_THROTTLE_EN`, 64 requests -> `rrdy` follows the LFSR pattern from seed A5, and all 64 rows return in order.
